// File: rtl/adder_four_sync_pkg.sv
// Shared constants and result payload for the registered 2-bit ripple-carry adder.
//   ADD_W      : operand width (bits of a and b)
//   RESULT_W   : result width including carry-out
//   result_t   : packed {carry, s1, s0} result payload
//   RESULT_RST : value loaded into the result flops on reset
package adder_four_sync_pkg;

    localparam int unsigned ADD_W    = 2;
    localparam int unsigned RESULT_W = 3;

    // Bit order matches the arithmetic value: carry is bit 2, s0 is bit 0.
    typedef struct packed {
        logic carry;
        logic s1;
        logic s0;
    } result_t;

    localparam result_t RESULT_RST = '0;

endpackage : adder_four_sync_pkg

// File: rtl/full_adder_cell.sv
// One-bit full-adder cell, purely combinational.
//   a, b : operand bits
//   cin  : carry in
//   s    : sum bit
//   cout : carry out
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    // Propagate term shared by sum and carry.
    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule : full_adder_cell

// File: rtl/adder_four_sync.sv
// Registered 2-bit ripple-carry adder: {Carry, s1, s0} = {a1, a0} + {b1, b0},
// captured one clock after the operands are sampled.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, clears the result
//   a0/a1 : operand A bits (LSB/MSB)
//   b0/b1 : operand B bits (LSB/MSB)
//   s0/s1 : registered sum bits
//   Carry : registered carry-out of bit 1
module adder_four_sync
    import adder_four_sync_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic a0,
    input  logic a1,
    input  logic b0,
    input  logic b1,
    output logic s0,
    output logic s1,
    output logic Carry
);

    logic [ADD_W-1:0]    a_vec;
    logic [ADD_W-1:0]    b_vec;
    logic [ADD_W-1:0]    sum_bits;
    logic [ADD_W:0]      carry_chain;
    logic [RESULT_W-1:0] sum_n;
    result_t             res_q;

    assign a_vec = {a1, a0};
    assign b_vec = {b1, b0};

    // Bit 0 has no carry-in.
    assign carry_chain[0] = 1'b0;

    // Ripple chain, LSB first.
    full_adder_cell u_fa0 (
        .a    (a_vec[0]),
        .b    (b_vec[0]),
        .cin  (carry_chain[0]),
        .s    (sum_bits[0]),
        .cout (carry_chain[1])
    );

    full_adder_cell u_fa1 (
        .a    (a_vec[1]),
        .b    (b_vec[1]),
        .cin  (carry_chain[1]),
        .s    (sum_bits[1]),
        .cout (carry_chain[2])
    );

    // Carry-out of the top cell is the true bit 2; the result never wraps.
    assign sum_n = {carry_chain[ADD_W], sum_bits};

    // Result flops: reset wins, otherwise load every edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_q <= RESULT_RST;
        end else begin
            res_q <= result_t'(sum_n);
        end
    end

    assign s0    = res_q.s0;
    assign s1    = res_q.s1;
    assign Carry = res_q.carry;

endmodule : adder_four_sync

// File: tb/tb_adder_four_sync.sv
module tb_adder_four_sync;

    logic clk;
    logic reset;
    logic a0, a1, b0, b1;
    logic s0, s1, Carry;

    int checks;
    int errors;

    typedef struct {
        bit       rst;
        int       a;
        int       b;
        int       exp;
        string    name;
    } vec_t;

    vec_t vecs[$];

    adder_four_sync dut (
        .clk   (clk),
        .reset (reset),
        .a0    (a0),
        .a1    (a1),
        .b0    (b0),
        .b1    (b1),
        .s0    (s0),
        .s1    (s1),
        .Carry (Carry)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: registered value after an edge is 0 under reset, else a+b.
    function automatic int ref_model(bit rst, int a, int b);
        if (rst) return 0;
        return a + b;
    endfunction

    task automatic drive(bit rst, int a, int b);
        logic [1:0] av;
        logic [1:0] bv;
        av    = 2'(a);
        bv    = 2'(b);
        reset = rst;
        a1    = av[1];
        a0    = av[0];
        b1    = bv[1];
        b0    = bv[0];
    endtask

    task automatic check(string name, int exp);
        logic [2:0] got;
        logic [2:0] want;
        got  = {Carry, s1, s0};
        want = 3'(exp);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %b want %b", name, got, want);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Vector table: a short directed prefix, the exhaustive sweep, then a mid-stream reset.
        vecs.push_back('{0, 2, 3, ref_model(0, 2, 3), "add_2p3"});
        vecs.push_back('{0, 3, 3, ref_model(0, 3, 3), "add_3p3"});
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                vecs.push_back('{0, a, b, ref_model(0, a, b), $sformatf("sweep_%0dp%0d", a, b)});
            end
        end
        vecs.push_back('{1, 3, 2, ref_model(1, 3, 2), "mid_reset"});
        vecs.push_back('{0, 1, 0, ref_model(0, 1, 0), "post_reset_1p0"});

        // Reset held two cycles with a=3, b=3.
        #1;
        drive(1, 3, 3);
        tick();
        check("reset_cyc0", 0);
        tick();
        check("reset_cyc1", 0);

        // Result persists across an input change until the next edge.
        drive(0, 2, 3);
        tick();
        check("hold_first_5", 5);
        drive(0, 3, 3);
        #3;
        check("hold_5_before_edge", 5);
        tick();
        check("hold_then_6", 6);

        // Table-driven vectors, each checked exactly one edge later.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].a, vecs[i].b);
            tick();
            check(vecs[i].name, vecs[i].exp);
        end

        // Inputs wiggling between edges must not reach the outputs.
        drive(0, 1, 2);
        tick();
        check("glitch_base", 3);
        for (int k = 0; k < 3; k++) begin
            drive(0, int'($urandom_range(3)), int'($urandom_range(3)));
            #2;
            check($sformatf("glitch_hold_%0d", k), 3);
        end
        drive(0, 2, 2);
        tick();
        check("glitch_next_edge", 4);

        // Randomized stream with occasional reset.
        for (int n = 0; n < 300; n++) begin
            bit ra;
            int ai;
            int bi;
            ra = ($urandom_range(9) == 0);
            ai = int'($urandom_range(3));
            bi = int'($urandom_range(3));
            drive(ra, ai, bi);
            tick();
            check($sformatf("rand_%0d_r%0d_%0dp%0d", n, ra, ai, bi), ref_model(ra, ai, bi));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_adder_four_sync

// File: doc/adder_four_sync.md
Name: adder_four_sync

Overview:
- Registered 2-bit ripple-carry adder, operands supplied as individual bit ports.
- Computes {Carry, s1, s0} = {a1, a0} + {b1, b0}.
- Result is captured in output flops on each rising clock edge.
- Leaf arithmetic block used in the datapath exercises; no handshake, free-running.

Parameters:
- none (operand width fixed at 2 bits)

Ports:
- clk    input   1  system clock, rising-edge active
- reset  input   1  synchronous, active-high reset
- a0     input   1  operand A bit 0 (LSB)
- a1     input   1  operand A bit 1 (MSB)
- b0     input   1  operand B bit 0 (LSB)
- b1     input   1  operand B bit 1 (MSB)
- s0     output  1  sum bit 0, registered
- s1     output  1  sum bit 1, registered
- Carry  output  1  carry-out of bit 1, registered

Behaviour:
- One clock; reset is synchronous and active-high (clk, reset).
- Reset: when reset=1 at a rising edge of clk, s0=0, s1=0 and Carry=0 after that edge. Reset has priority over the addition.
- Combinational core:
  - Bit 0 is a full-adder cell with carry-in 0: s0_n = a0^b0, c0 = a0&b0.
  - Bit 1 is a full-adder cell: s1_n = a1^b1^c0, Carry_n = (a1&b1)|(c0&(a1^b1)).
- Latency is exactly 1 cycle. Inputs sampled at edge k appear on the outputs after edge k and hold until edge k+1.
- Outputs update on every non-reset edge. There is no enable and no hold state.
- Outputs change only on clk edges. No combinational path from inputs to outputs.
- Arithmetic is unsigned, range 0..6. The 3-bit result never wraps; Carry is the true bit 2.
- Reset mid-operation: the pending result is discarded. The first valid result appears on the first edge after reset deasserts, computed from the inputs at that edge.
- X/Z on inputs is not handled; the bench must drive known values.
- Power-up, before the first reset: output values are unspecified. The bench must apply reset first.

Decomposition:
- Shared package:
  - constant ADD_W = 2
  - constant RESULT_W = 3
  - reset value constant for the 3-bit result (all zeros)
- One sub-module, full_adder_cell (a, b, cin -> s, cout), purely combinational. Instantiate twice in a ripple chain; tie the bit-0 cin to 0.
- Top level holds only the ripple chain and the 3 output flops.

Test Plan:
- Reset: hold reset=1 for 2 cycles with a=3, b=3 -> s0=0, s1=0, Carry=0 throughout.
- Reset released, a1=1 a0=0, b1=1 b0=1 (2+3) -> one edge later Carry=1, s1=0, s0=1 (5).
- Next cycle a1=1 a0=1, b1=1 b0=1 (3+3) -> one edge later Carry=1, s1=1, s0=0 (6). The previous output (5) must persist until that edge.
- Exhaustive sweep of all 16 {a1,a0,b1,b0} combinations, one per cycle -> each output equals a+b, delayed by exactly 1 cycle. Checks include 0+0 -> 000 and 1+1 -> 010 (internal carry into bit 1).
- Reset asserted mid-stream while a=3, b=2 -> outputs are 000 after the reset edge. On deassert with a=1, b=0, the next edge gives 001.
- Change inputs between clock edges (no edge in between) -> outputs do not move until the next rising edge of clk.
